sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 1665219701, SHALL be the 32-bit value expected at system-ID address 0.
REQ-002 Parameter EXPECTED_TS, default 1375634013, SHALL be the 32-bit value expected at system-ID address 1.
REQ-003 Parameter SETTLE, default 1, range 0..15, SHALL set the number of extra wait cycles per read phase.
REQ-004 Parameter AUTO_START, default 1, SHALL launch one check after reset release when set to 1.
REQ-005 clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 reset_n: input, 1 bit, synchronous active-low reset.
REQ-007 start: input, 1 bit, request a check; sampled only in IDLE.
REQ-008 sysid_address: output, 1 bit, address to the system-ID slave (0 = ID, 1 = timestamp).
REQ-009 sysid_read: output, 1 bit, high while a read phase is active.
REQ-010 sysid_readdata: input, 32 bits, combinational read data returned by the system-ID slave.
REQ-011 busy: output, 1 bit, high in every state except IDLE.
REQ-012 done: output, 1 bit, single-cycle pulse when a check completes.
REQ-013 id_ok, ts_ok, pass: outputs, 1 bit each, compare results; pass = id_ok AND ts_ok.
REQ-014 id_value, ts_value: outputs, 32 bits each, captured read data.
REQ-015 err_count: output, 8 bits, number of completed checks with pass = 0.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_ID, RD_TS and DONE.
REQ-017 IDLE -> RD_ID SHALL occur when start = 1, or on the first cycle after reset release when AUTO_START = 1.
REQ-018 On entry to RD_ID, id_ok, ts_ok and pass SHALL clear to 0; id_value, ts_value and err_count SHALL hold.
REQ-019 RD_ID SHALL last exactly SETTLE+1 cycles with sysid_address = 0 and sysid_read = 1.
REQ-020 On the clock edge ending the last RD_ID cycle, id_value SHALL capture sysid_readdata and id_ok SHALL be set to (sysid_readdata == EXPECTED_ID).
REQ-021 The FSM SHALL then enter RD_TS.
REQ-022 RD_TS SHALL last exactly SETTLE+1 cycles with sysid_address = 1 and sysid_read = 1.
REQ-023 On the clock edge ending the last RD_TS cycle, ts_value SHALL capture sysid_readdata, ts_ok SHALL be set to the timestamp compare and pass SHALL be updated.
REQ-024 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-025 Total latency from start sampled at cycle T SHALL be: done = 1 at cycle T+2*(SETTLE+1)+1; pass valid from that cycle.
REQ-026 In IDLE and DONE, sysid_read and sysid_address SHALL both be 0.
REQ-027 A start pulse while busy = 1 (including in DONE) SHALL be ignored and SHALL NOT be queued.
REQ-028 err_count SHALL increment on the edge entering DONE when pass = 0, and SHALL saturate at 255.
REQ-029 Results SHALL hold their values in IDLE until the next check starts.
REQ-030 A per-phase wait counter SHALL be 4 bits wide and SHALL reset to 0 on each phase entry.

Reset
REQ-031 With reset_n = 0 at a rising edge, the block SHALL set state = IDLE, busy = 0, done = 0, sysid_read = 0, sysid_address = 0, id_ok = ts_ok = pass = 0, id_value = ts_value = 0, err_count = 0 and wait counter = 0.
REQ-032 Reset asserted in any state, mid-read included, SHALL abort the check without producing a done pulse.
REQ-033 The AUTO_START launch SHALL fire exactly once per reset release.

Verification
REQ-034 Matching data (AUTO_START = 0, SETTLE = 1): slave returns 1665219701 / 1375634013; start pulse at T -> done at T+5, id_ok = ts_ok = pass = 1, err_count = 0.
REQ-035 Timestamp mismatch: slave returns 0x00000000 at address 1 -> id_ok = 1, ts_ok = 0, pass = 0, ts_value = 0, err_count = 1.
REQ-036 Busy-ignore: start held high for 10 cycles -> exactly one check is run; a second start pulse in DONE produces no second check.
REQ-037 Mid-check reset: reset_n = 0 during RD_TS -> next cycle busy = 0, all results 0, no done pulse; with AUTO_START = 1, a fresh check follows release.
REQ-038 Timing sweep: SETTLE = 0 gives done at T+3; SETTLE = 15 gives done at T+33; sysid_address is 0 for exactly SETTLE+1 cycles, then 1 for SETTLE+1 cycles.
REQ-039 Saturation: 260 consecutive failing checks -> err_count = 255, unchanged by further failures.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system-ID slave (ID, then timestamp), compares both
// against the expected build values and keeps a saturating failure count.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID = 32'd1665219701,
   parameter logic [31:0] EXPECTED_TS = 32'd1375634013,
   parameter int unsigned SETTLE      = 1,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [7:0]  err_count
);
   typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;
   localparam logic [3:0] SETTLE_W = 4'(SETTLE);
   state_t      r_state, w_next;
   logic [3:0]  r_wait;
   logic        r_auto;
   logic        r_id_ok, r_ts_ok, r_pass;
   logic [31:0] r_id_value, r_ts_value;
   logic [7:0]  r_err_count;
   logic        w_last, w_launch, w_id_end, w_ts_end, w_ts_match, w_pass_new;
   assign w_last     = r_wait == SETTLE_W;
   assign w_launch   = r_state == IDLE && w_next == RD_ID;
   assign w_id_end   = r_state == RD_ID && w_last;
   assign w_ts_end   = r_state == RD_TS && w_last;
   assign w_ts_match = sysid_readdata == EXPECTED_TS;
   assign w_pass_new = r_id_ok && w_ts_match;
   assign busy          = r_state != IDLE;
   assign done          = r_state == DONE;
   assign sysid_read    = r_state == RD_ID || r_state == RD_TS;
   assign sysid_address = r_state == RD_TS;
   assign id_ok     = r_id_ok;
   assign ts_ok     = r_ts_ok;
   assign pass      = r_pass;
   assign id_value  = r_id_value;
   assign ts_value  = r_ts_value;
   assign err_count = r_err_count;
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = (start || r_auto) ? RD_ID : IDLE;
         RD_ID:   w_next = w_last ? RD_TS : RD_ID;
         RD_TS:   w_next = w_last ? DONE : RD_TS;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= (w_next != r_state || !sysid_read) ? 4'd0 : r_wait + 4'd1;
      end
   end
   // r_auto is re-armed by every reset, so the auto launch fires once per release
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_auto      <= AUTO_START;
         r_id_ok     <= 1'b0;
         r_ts_ok     <= 1'b0;
         r_pass      <= 1'b0;
         r_id_value  <= '0;
         r_ts_value  <= '0;
         r_err_count <= '0;
      end else begin
         if (w_launch) begin
            r_auto  <= 1'b0;
            r_id_ok <= 1'b0;
            r_ts_ok <= 1'b0;
            r_pass  <= 1'b0;
         end
         if (w_id_end) begin
            r_id_value <= sysid_readdata;
            r_id_ok    <= sysid_readdata == EXPECTED_ID;
         end
         if (w_ts_end) begin
            r_ts_value <= sysid_readdata;
            r_ts_ok    <= w_ts_match;
            r_pass     <= w_pass_new;
            if (!w_pass_new && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed checks on three configurations of sysid_checker
// (SETTLE 1 manual start, SETTLE 0 manual start, SETTLE 15 auto start).
module tb_sysid_checker;
   localparam logic [31:0] EID = 32'd1665219701;
   localparam logic [31:0] ETS = 32'd1375634013;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic [31:0] id_mem, ts_mem;
   int checks = 0, failures = 0;
   logic rn1, st1, ad1, rd1, by1, dn1, io1, to1, ps1;
   logic rn0, st0, ad0, rd0, by0, dn0, io0, to0, ps0;
   logic rn15, st15, ad15, rd15, by15, dn15, io15, to15, ps15;
   logic [31:0] iv1, tv1, iv0, tv0, iv15, tv15, rdat1, rdat0, rdat15;
   logic [7:0] ec1, ec0, ec15;
   assign rdat1  = ad1  ? ts_mem : id_mem;
   assign rdat0  = ad0  ? ts_mem : id_mem;
   assign rdat15 = ad15 ? ts_mem : id_mem;
   sysid_checker #(.SETTLE(1), .AUTO_START(1'b0)) u_d1 (
      .clk(clk), .reset_n(rn1), .start(st1), .sysid_address(ad1), .sysid_read(rd1),
      .sysid_readdata(rdat1), .busy(by1), .done(dn1), .id_ok(io1), .ts_ok(to1),
      .pass(ps1), .id_value(iv1), .ts_value(tv1), .err_count(ec1));
   sysid_checker #(.SETTLE(0), .AUTO_START(1'b0)) u_d0 (
      .clk(clk), .reset_n(rn0), .start(st0), .sysid_address(ad0), .sysid_read(rd0),
      .sysid_readdata(rdat0), .busy(by0), .done(dn0), .id_ok(io0), .ts_ok(to0),
      .pass(ps0), .id_value(iv0), .ts_value(tv0), .err_count(ec0));
   sysid_checker #(.SETTLE(15), .AUTO_START(1'b1)) u_d15 (
      .clk(clk), .reset_n(rn15), .start(st15), .sysid_address(ad15), .sysid_read(rd15),
      .sysid_readdata(rdat15), .busy(by15), .done(dn15), .id_ok(io15), .ts_ok(to15),
      .pass(ps15), .id_value(iv15), .ts_value(tv15), .err_count(ec15));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rn1 = 0; rn0 = 0; rn15 = 0; st1 = 0; st0 = 0; st15 = 0;
      id_mem = EID; ts_mem = ETS;
      repeat (3) tick;
      checks++;
      if ({by1, dn1, rd1, ad1, io1, to1, ps1, ec1} !== 15'd0 || iv1 !== 32'd0 || tv1 !== 32'd0) begin
         failures++; $display("FAIL reset_d1 flags=%b ec=%0d iv=%0h tv=%0h exp all 0", {by1, dn1, rd1, ad1, io1, to1, ps1}, ec1, iv1, tv1);
      end
      checks++;
      if ({by15, dn15, rd15, ad15, io15, to15, ps15, ec15} !== 15'd0 || iv15 !== 32'd0 || tv15 !== 32'd0) begin
         failures++; $display("FAIL reset_d15 flags=%b ec=%0d iv=%0h tv=%0h exp all 0", {by15, dn15, rd15, ad15, io15, to15, ps15}, ec15, iv15, tv15);
      end
      rn1 = 1; rn0 = 1;
      repeat (2) tick;
      checks++;
      if ({by1, by0} !== 2'b00) begin
         failures++; $display("FAIL no_autostart busy=%b exp 00", {by1, by0});
      end
   endtask
   task automatic test_match;
      logic [3:0] e;
      st1 = 1; tick; st1 = 0;
      for (int k = 1; k <= 6; k++) begin
         e = k <= 2 ? 4'b1010 : k <= 4 ? 4'b1011 : k == 5 ? 4'b1100 : 4'b0000;
         checks++;
         if ({by1, dn1, rd1, ad1} !== e) begin
            failures++; $display("FAIL match_seq k=%0d busy/done/read/addr=%b exp %b", k, {by1, dn1, rd1, ad1}, e);
         end
         if (k == 5) begin
            checks++;
            if ({io1, to1, ps1, ec1} !== {3'b111, 8'd0} || iv1 !== EID || tv1 !== ETS) begin
               failures++; $display("FAIL match_res ok=%b ec=%0d iv=%0d tv=%0d exp 111 0 %0d %0d", {io1, to1, ps1}, ec1, iv1, tv1, EID, ETS);
            end
         end
         tick;
      end
      checks++;
      if (ps1 !== 1'b1 || iv1 !== EID) begin
         failures++; $display("FAIL match_hold pass=%b iv=%0d exp 1 %0d", ps1, iv1, EID);
      end
   endtask
   task automatic test_ts_mismatch;
      ts_mem = 32'd0;
      st1 = 1; tick; st1 = 0;
      checks++;
      if ({io1, to1, ps1} !== 3'b000 || iv1 !== EID) begin
         failures++; $display("FAIL mis_clear ok=%b iv=%0d exp 000 %0d", {io1, to1, ps1}, iv1, EID);
      end
      repeat (4) tick;
      checks++;
      if ({dn1, io1, to1, ps1} !== 4'b1100 || tv1 !== 32'd0 || ec1 !== 8'd1) begin
         failures++; $display("FAIL mis_res done/ok=%b tv=%0h ec=%0d exp 1100 0 1", {dn1, io1, to1, ps1}, tv1, ec1);
      end
      tick;
      checks++;
      if ({by1, ps1, ec1} !== {2'b00, 8'd1}) begin
         failures++; $display("FAIL mis_hold busy/pass=%b ec=%0d exp 00 1", {by1, ps1}, ec1);
      end
   endtask
   task automatic test_sweep;
      logic [3:0] e;
      bit seen;
      ts_mem = ETS;
      st0 = 1; tick; st0 = 0;
      for (int k = 1; k <= 4; k++) begin
         e = k == 1 ? 4'b1010 : k == 2 ? 4'b1011 : k == 3 ? 4'b1100 : 4'b0000;
         checks++;
         if ({by0, dn0, rd0, ad0} !== e) begin
            failures++; $display("FAIL s0_seq k=%0d busy/done/read/addr=%b exp %b", k, {by0, dn0, rd0, ad0}, e);
         end
         if (k == 3) begin
            checks++;
            if (ps0 !== 1'b1) begin
               failures++; $display("FAIL s0_pass pass=%b exp 1", ps0);
            end
         end
         tick;
      end
      rn15 = 1; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick;
         seen = dn15;
      end
      checks++;
      if (!seen || ps15 !== 1'b1) begin
         failures++; $display("FAIL auto_start done_seen=%b pass=%b exp 1 1", seen, ps15);
      end
      tick;
      st15 = 1; tick; st15 = 0;
      for (int k = 1; k <= 34; k++) begin
         e = k <= 16 ? 4'b1010 : k <= 32 ? 4'b1011 : k == 33 ? 4'b1100 : 4'b0000;
         checks++;
         if ({by15, dn15, rd15, ad15} !== e) begin
            failures++; $display("FAIL s15_seq k=%0d busy/done/read/addr=%b exp %b", k, {by15, dn15, rd15, ad15}, e);
         end
         tick;
      end
   endtask
   task automatic test_back_to_back;
      int n_done;
      bit seen;
      n_done = 0; seen = 0;
      st15 = 1;
      repeat (10) begin
         tick;
         n_done += int'(dn15);
      end
      st15 = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick;
         seen = dn15;
      end
      n_done += int'(seen);
      st15 = 1; tick; st15 = 0;
      checks++;
      if (by15 !== 1'b0) begin
         failures++; $display("FAIL done_start_ignored busy=%b exp 0", by15);
      end
      repeat (40) begin
         tick;
         n_done += int'(dn15);
      end
      checks++;
      if (n_done !== 1) begin
         failures++; $display("FAIL busy_ignore done_pulses=%0d exp 1", n_done);
      end
   endtask
   task automatic test_mid_reset;
      int n_done;
      st15 = 1; tick; st15 = 0;
      repeat (19) tick;
      checks++;
      if ({rd15, ad15} !== 2'b11 || iv15 !== EID) begin
         failures++; $display("FAIL mid_pre read/addr=%b iv=%0d exp 11 %0d", {rd15, ad15}, iv15, EID);
      end
      rn15 = 0; tick;
      checks++;
      if ({by15, dn15, rd15, ad15, io15, to15, ps15, ec15} !== 15'd0 || iv15 !== 32'd0 || tv15 !== 32'd0) begin
         failures++; $display("FAIL mid_reset flags=%b ec=%0d iv=%0h tv=%0h exp all 0", {by15, dn15, rd15, ad15, io15, to15, ps15}, ec15, iv15, tv15);
      end
      rn15 = 1; n_done = 0;
      repeat (80) begin
         tick;
         n_done += int'(dn15);
      end
      checks++;
      if (n_done !== 1 || ps15 !== 1'b1) begin
         failures++; $display("FAIL mid_restart done_pulses=%0d pass=%b exp 1 1", n_done, ps15);
      end
   endtask
   task automatic test_saturation;
      int n_done;
      n_done = 0;
      ts_mem = 32'd0;
      st0 = 1;
      for (int i = 0; i < 1200 && n_done < 260; i++) begin
         tick;
         if (dn0) begin
            n_done++;
            if (n_done == 254) begin
               checks++;
               if (ec0 !== 8'd254) begin
                  failures++; $display("FAIL sat_254 err_count=%0d exp 254", ec0);
               end
            end
         end
      end
      st0 = 0;
      checks++;
      if (n_done !== 260 || ec0 !== 8'd255) begin
         failures++; $display("FAIL sat_260 checks_run=%0d err_count=%0d exp 260 255", n_done, ec0);
      end
      tick;
      st0 = 1; tick; st0 = 0;
      repeat (3) tick;
      checks++;
      if (ec0 !== 8'd255 || ps0 !== 1'b0) begin
         failures++; $display("FAIL sat_hold err_count=%0d pass=%b exp 255 0", ec0, ps0);
      end
   endtask
   initial begin
      test_reset;
      test_match;
      test_ts_mismatch;
      test_sweep;
      test_back_to_back;
      test_mid_reset;
      test_saturation;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
